// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: produces stall/flush controls for load-use, taken-branch and LM/SM sequencing.
// Optional perf counters are enabled by defining HAZ_PERF_CNT_EN; otherwise stall_cnt/flush_cnt are tied to 0.
module pipeline_hazard_ctrl #(
    parameter logic [3:0] LW_OP = 4'b0100,
    parameter logic [3:0] LM_OP = 4'b0110,
    parameter logic [3:0] SM_OP = 4'b0111,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      rr_IR,
    input  logic [15:0]      ex_IR,
    input  logic [2:0]       ex_WriteAdd,
    input  logic             br_taken,
    output logic             stall_pc,
    output logic             stall_ifrr,
    output logic             flush_ifrr,
    output logic             flush_rrex,
    output logic             first_multiple,
    output logic [2:0]       multi_reg,
    output logic             multi_active,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MULTI = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_list;
    logic [7:0] w_list_nxt;
    logic [7:0] w_list;
    logic       w_load_use;
    logic       w_rr_multi;
    logic       w_beat;
    logic       w_more;
    logic [2:0] w_lowest;
    logic       w_unused;

    assign w_unused   = ^ex_IR[11:0];
    assign w_load_use = (ex_IR[15:12] == LW_OP) &&
                        ((ex_WriteAdd == rr_IR[11:9]) || (ex_WriteAdd == rr_IR[8:6]));
    assign w_rr_multi = (rr_IR[15:12] == LM_OP) || (rr_IR[15:12] == SM_OP);

    // On the entry cycle the list comes straight from RR so the first beat costs no extra cycle.
    assign w_list = (r_state == ST_MULTI) ? r_list : rr_IR[7:0];
    assign w_beat = !br_taken &&
                    ((r_state == ST_MULTI) || (w_rr_multi && (rr_IR[7:0] != 8'd0) && !w_load_use));
    assign w_more = (w_list & (w_list - 8'd1)) != 8'd0;

    always_comb begin
        w_lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_list[i]) w_lowest = 3'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_list  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_list  <= w_list_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_list_nxt  = 8'd0;
        if (w_beat && w_more) begin
            w_state_nxt = ST_MULTI;
            w_list_nxt  = w_list & (w_list - 8'd1);
        end
    end

    always_comb begin
        stall_pc       = 1'b0;
        stall_ifrr     = 1'b0;
        flush_ifrr     = 1'b0;
        flush_rrex     = 1'b0;
        first_multiple = 1'b0;
        multi_reg      = 3'd0;
        multi_active   = 1'b0;
        if (reset) begin
            if (br_taken) begin
                flush_ifrr = 1'b1;
                flush_rrex = 1'b1;
            end else if (w_beat) begin
                multi_active   = 1'b1;
                multi_reg      = w_lowest;
                first_multiple = (r_state == ST_IDLE);
                stall_pc       = w_more;
                stall_ifrr     = w_more;
            end else if (w_load_use) begin
                stall_pc   = 1'b1;
                stall_ifrr = 1'b1;
                flush_rrex = 1'b1;
            end else if (w_rr_multi) begin
                // Empty register list: the LM/SM retires as a bubble.
                flush_rrex = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_pc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (br_taken && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
